muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller attached to the EX stage.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs them iteratively, one bit per cycle, on 32-bit operands.
- Owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Stalls the pipeline while a later access to HI/LO arrives before the current operation is finished.

---
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_sequencer.sv | 157 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and result bus between the EX stage (master) and the multiply/divide
// sequencer (slave).
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       instReg;
   logic [WIDTH-1:0] readRs;
   logic [WIDTH-1:0] readRt;
   logic             busy;
   logic             stallEx;
   logic             done;
   logic             divZero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] outMd;

   modport master (
      output start, instReg, readRs, readRt,
      input  busy, stallEx, done, divZero, hi, lo, outMd
   );

   modport slave (
      input  start, instReg, readRs, readRt,
      output busy, stallEx, done, divZero, hi, lo, outMd
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative one-bit-per-cycle multiply/divide unit owning HI/LO, with EX-stage
// stall generation for HI/LO accesses that arrive while an operation is in flight.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [5:0] F_MFHI = 6'h10;
   localparam logic [5:0] F_MTHI = 6'h11;
   localparam logic [5:0] F_MTLO = 6'h13;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               dz_q, dz_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   logic               is_muldiv, op_signed, op_div;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   // funct 0x18..0x1B: bit0 = unsigned, bit1 = divide
   assign is_muldiv = (bus.instReg[5:2] == 4'b0110);
   assign op_signed = ~bus.instReg[0];
   assign op_div    = bus.instReg[1];
   assign a_abs     = (op_signed && bus.readRs[WIDTH-1]) ? -bus.readRs : bus.readRs;
   assign b_abs     = (op_signed && bus.readRt[WIDTH-1]) ? -bus.readRt : bus.readRt;

   // Multiply: accumulator is {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: accumulator is {partial remainder, dividend bits shifting into quotient}.
   assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff   = div_rem_sh - {1'b0, opnd_q};
   assign div_next   = {(div_diff[WIDTH] ? div_rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      dz_d       = dz_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (is_muldiv) begin
                  is_div_d = op_div;
                  if (op_div && (bus.readRt == '0)) begin
                     dz_d    = 1'b1;
                     state_d = S_FIX;
                  end else begin
                     dz_d      = 1'b0;
                     cnt_d     = '0;
                     neg_d     = op_signed && (bus.readRs[WIDTH-1] ^ bus.readRt[WIDTH-1]);
                     rem_neg_d = op_signed && bus.readRs[WIDTH-1];
                     acc_d     = op_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                     opnd_d    = op_div ? b_abs : a_abs;
                     state_d   = S_RUN;
                  end
               end else if (bus.instReg == F_MTHI) begin
                  hi_d = bus.readRs;
               end else if (bus.instReg == F_MTLO) begin
                  lo_d = bus.readRs;
               end
            end
         end
         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            done_d     = 1'b1;
            div_zero_d = dz_q;
            dz_d       = 1'b0;
            if (!dz_q) begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         dz_q       <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         dz_q       <= dz_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.stallEx = bus.start & bus.busy;
   assign bus.done    = done_q;
   assign bus.divZero = div_zero_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.outMd   = (bus.instReg == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic
// reference model of HI/LO.
module tb_muldiv_sequencer;
   localparam int W = 32;
   localparam logic [5:0] MULT  = 6'h18;
   localparam logic [5:0] MULTU = 6'h19;
   localparam logic [5:0] DIV   = 6'h1A;
   localparam logic [5:0] DIVU  = 6'h1B;
   localparam logic [5:0] MFHI  = 6'h10;
   localparam logic [5:0] MTHI  = 6'h11;
   localparam logic [5:0] MFLO  = 6'h12;
   localparam logic [5:0] MTLO  = 6'h13;

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi, m_lo;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Result {hi, lo} of a mul/div from plain integer arithmetic.
   function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = {h, l};
      case (f)
         MULT:  p = 64'(sa * sb);
         MULTU: p = {32'h0, a} * {32'h0, b};
         DIV:   if (b != 0) begin
                   q = sa / sb;
                   r = sa % sb;
                   p = {r[31:0], q[31:0]};
                end
         DIVU:  if (b != 0) p = {a % b, a / b};
         default: p = {h, l};
      endcase
      return p;
   endfunction

   task automatic mul_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      int n_busy = 0, n_done = 0, n_dz = 0, n_both = 0;
      bit fin = 0;
      bit dz;
      dz  = f[1] && (b == 0);
      exp = ref_op(f, a, b, m_hi, m_lo);
      @(negedge clk);
      bus.start = 1'b1; bus.instReg = f; bus.readRs = a; bus.readRt = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.busy) n_busy++;
         if (bus.done) n_done++;
         if (bus.divZero) n_dz++;
         if (bus.divZero && bus.done) n_both++;
         if (!bus.busy && !bus.done) begin
            fin = 1;
            break;
         end
      end
      check("op_finish", 64'(fin), 64'(1));
      check("busy_cycles", 64'(n_busy), 64'(dz ? 33 : 0) + 64'(dz ? 0 : 33) - 64'(dz ? 32 : 0));
      check("done_pulses", 64'(n_done), 64'(1));
      check("divzero_pulses", 64'(n_dz), 64'(dz ? 1 : 0));
      check("divzero_with_done", 64'(n_both), 64'(dz ? 1 : 0));
      {m_hi, m_lo} = exp;
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
      $display("op %h a=%h b=%h -> hi=%h lo=%h busy=%0d", f, a, b, bus.hi, bus.lo, n_busy);
   endtask

   task automatic mt(input logic [5:0] f, input logic [31:0] v);
      @(negedge clk);
      bus.start = 1'b1; bus.instReg = f; bus.readRs = v; bus.readRt = $urandom;
      @(posedge clk);
      #1 bus.start = 1'b0;
      if (f == MTHI) m_hi = v;
      else m_lo = v;
      @(negedge clk);
      check("mt_busy", 64'(bus.busy), 64'(0));
      check("mt_hi", 64'(bus.hi), 64'(m_hi));
      check("mt_lo", 64'(bus.lo), 64'(m_lo));
      $display("mt %h v=%h -> hi=%h lo=%h", f, v, bus.hi, bus.lo);
   endtask

   task automatic mf(input logic [5:0] f);
      @(negedge clk);
      bus.start = 1'b1; bus.instReg = f;
      #1;
      check("mf_stall", 64'(bus.stallEx), 64'(0));
      check("mf_outmd", 64'(bus.outMd), 64'((f == MFHI) ? m_hi : m_lo));
      $display("mf %h -> outMd=%h", f, bus.outMd);
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // MULT followed by a held MFLO; optionally reset once the counter reaches 10.
   task automatic hazard(input logic [31:0] a, input logic [31:0] b, input bit do_reset);
      logic [63:0] exp;
      int n_stall = 0, n_done = 0;
      bit fin = 0;
      exp = ref_op(MULT, a, b, m_hi, m_lo);
      @(negedge clk);
      bus.start = 1'b1; bus.instReg = MULT; bus.readRs = a; bus.readRt = b;
      @(posedge clk);
      #1 bus.instReg = MFLO; bus.readRs = $urandom; bus.readRt = $urandom;
      if (!do_reset) begin
         for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.stallEx) n_stall++;
            else begin
               fin = 1;
               break;
            end
         end
         {m_hi, m_lo} = exp;
         check("hz_finish", 64'(fin), 64'(1));
         check("hz_stall_cycles", 64'(n_stall), 64'(33));
         check("hz_done", 64'(bus.done), 64'(1));
         check("hz_outmd", 64'(bus.outMd), 64'(m_lo));
         @(posedge clk);
         #1 bus.start = 1'b0;
         check("hz_hi", 64'(bus.hi), 64'(m_hi));
         $display("hazard a=%h b=%h stall=%0d outMd=%h", a, b, n_stall, bus.outMd);
      end else begin
         repeat (10) @(posedge clk);
         #2;
         check("rst_pre_stall", 64'(bus.stallEx), 64'(1));
         reset = 1'b1;
         #1;
         m_hi = '0;
         m_lo = '0;
         check("rst_hi", 64'(bus.hi), 64'(0));
         check("rst_lo", 64'(bus.lo), 64'(0));
         check("rst_busy", 64'(bus.busy), 64'(0));
         check("rst_done", 64'(bus.done), 64'(0));
         check("rst_stall", 64'(bus.stallEx), 64'(0));
         @(negedge clk);
         reset = 1'b0;
         bus.start = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
         end
         check("rst_no_done", 64'(n_done), 64'(0));
         check("rst_idle", 64'(bus.busy), 64'(0));
         $display("hazard reset at cnt=10 hi=%h lo=%h", bus.hi, bus.lo);
      end
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'(($urandom_range(0, 15)));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [5:0]  f;
      logic [31:0] a, b;
      reset = 1'b1;
      bus.start = 1'b0; bus.instReg = '0; bus.readRs = '0; bus.readRt = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(posedge clk);
      #1;
      check("init_hi", 64'(bus.hi), 64'(0));
      check("init_lo", 64'(bus.lo), 64'(0));
      check("init_busy", 64'(bus.busy), 64'(0));
      check("init_done", 64'(bus.done), 64'(0));
      @(negedge clk);
      reset = 1'b0;

      mt(MTHI, 32'hDEAD_BEEF);
      mt(MTLO, 32'hCAFE_F00D);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      m_hi = '0; m_lo = '0;
      check("midrst_hi", 64'(bus.hi), 64'(0));
      check("midrst_lo", 64'(bus.lo), 64'(0));
      check("midrst_div0", 64'(bus.divZero), 64'(0));
      @(negedge clk);
      reset = 1'b0;

      mul_div(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max_hi", 64'(bus.hi), 64'(32'hFFFF_FFFE));
      check("multu_max_lo", 64'(bus.lo), 64'(32'h0000_0001));
      mul_div(MULT, 32'hFFFF_FFFD, 32'd7);
      check("mult_neg_lo", 64'(bus.lo), 64'(32'hFFFF_FFEB));
      mul_div(DIV, 32'hFFFF_FFF9, 32'd2);
      check("div_neg_lo", 64'(bus.lo), 64'(32'hFFFF_FFFD));
      mul_div(DIVU, 32'd100, 32'd7);
      check("divu_hi", 64'(bus.hi), 64'(2));
      mul_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf_lo", 64'(bus.lo), 64'(32'h8000_0000));
      mt(MTHI, 32'h1234);
      mt(MTLO, 32'h5678);
      mul_div(DIV, 32'd55, 32'd0);
      check("dz_lo_kept", 64'(bus.lo), 64'(32'h5678));
      mf(MFLO);
      mf(MFHI);
      mul_div(DIVU, 32'hFFFF_0000, 32'd0);

      hazard(32'hFFFF_FFF0, 32'd12345, 1'b0);
      hazard(32'h0001_2345, 32'hFFFF_0001, 1'b1);

      for (int n = 0; n < 30; n++) begin
         f = MULT + 6'($urandom_range(0, 3));
         a = pick_val();
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : pick_val();
         mul_div(f, a, b);
         if ($urandom_range(0, 2) == 0) mf($urandom_range(0, 1) ? MFHI : MFLO);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
